// File: rtl/dsp_mac_pkg.sv
// Shared state, tag and OPMODE definitions for the DSP48A1 MAC sequencer.
package dsp_mac_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FEED    = 3'd1,
      DRAIN   = 3'd2,
      CAPTURE = 3'd3,
      HOLD    = 3'd4
   } state_e;

   // X=M, Z=0 seeds the accumulator; X=M, Z=P accumulates. Upper bits keep add, no carry-in, no pre-add.
   localparam logic [7:0] OPM_IDLE  = 8'h00;
   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC   = 8'h09;

   typedef struct packed {
      logic v;
      logic first;
      logic last;
   } tag_t;

   localparam tag_t TAG_NONE = '0;

   function automatic logic [7:0] tag_opmode(input logic v, input logic first);
      if (!v) return OPM_IDLE;
      return first ? OPM_FIRST : OPM_ACC;
   endfunction

endpackage

// File: rtl/dsp_mac_tag_pipe.sv
// Tag shift register that follows each accepted sample through the slice A1->M->P pipeline.
// Stage M_LAT-2 selects OPMODE, stage M_LAT-1 enables the P register.
module dsp_mac_tag_pipe
   import dsp_mac_pkg::*;
#(
   parameter int M_LAT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic in_v,
   input  logic in_first,
   input  logic in_last,
   output logic front_v,
   output logic front_first,
   output logic front_busy,
   output logic back_v,
   output logic back_last
);

   tag_t tag_q [M_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < M_LAT; i++) tag_q[i] <= TAG_NONE;
      end else if (flush) begin
         for (int i = 0; i < M_LAT; i++) tag_q[i] <= TAG_NONE;
      end else begin
         tag_q[0] <= '{v: in_v, first: in_first, last: in_last};
         for (int i = 1; i < M_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Anything still ahead of the P stage means the final sum is not yet complete.
   always_comb begin
      front_busy = 1'b0;
      for (int i = 0; i < M_LAT - 1; i++) front_busy = front_busy | tag_q[i].v;
   end

   assign front_v     = tag_q[M_LAT-2].v;
   assign front_first = tag_q[M_LAT-2].first;
   assign back_v      = tag_q[M_LAT-1].v;
   assign back_last   = tag_q[M_LAT-1].last;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streaming multiply-accumulate sequencer driving one DSP48A1 slice (A1/B1/M/P/OPMODE regs on).
// Build option DSP_MAC_OVF_EN adds dsp_carryout input and a sticky result_ovf output.
module dsp_mac_sequencer
   import dsp_mac_pkg::*;
#(
   parameter int LEN_W = 8,
   parameter int M_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [17:0]      s_a,
   input  logic [17:0]      s_b,
   output logic [17:0]      dsp_a,
   output logic [17:0]      dsp_b,
   output logic             dsp_cea,
   output logic             dsp_ceb,
   output logic             dsp_cem,
   output logic             dsp_ceopmode,
   output logic             dsp_cep,
   output logic             dsp_rstp,
   output logic [7:0]       dsp_opmode,
   input  logic [47:0]      dsp_p,
`ifdef DSP_MAC_OVF_EN
   input  logic             dsp_carryout,
   output logic             result_ovf,
`endif
   output logic [47:0]      result,
   output logic             result_valid,
   input  logic             result_ready
);

   // state   | meaning
   // IDLE    | waiting for start; abort ignored
   // FEED    | accepting sample pairs until count reaches zero
   // DRAIN   | no new samples; waiting for the last product to reach P
   // CAPTURE | P holds the final sum; copy it into result
   // HOLD    | result_valid high until result_ready

   state_e           state;
   logic [LEN_W-1:0] count;
   logic             first_pend;
   logic             ce_on;
   logic             accept;
   logic             flush;
   logic             cnt_last;
   logic             drain_done;
   logic             front_v;
   logic             front_first;
   logic             front_busy;
   logic             back_v;
   logic             back_last;

   assign accept   = s_valid & s_ready;
   assign flush    = abort & busy;
   assign cnt_last = (count == LEN_W'(1));

   assign busy         = (state != IDLE);
   assign s_ready      = (state == FEED);
   assign result_valid = (state == HOLD);

   assign dsp_a        = s_a;
   assign dsp_b        = s_b;
   assign dsp_cea      = accept;
   assign dsp_ceb      = accept;
   assign dsp_cem      = ce_on;
   assign dsp_ceopmode = ce_on;
   assign dsp_cep      = back_v;
   assign dsp_opmode   = tag_opmode(front_v, front_first);

   // Leave DRAIN in the cycle the last tag sits at the P stage, so CAPTURE sees the completed sum.
   assign drain_done = back_v & back_last & ~front_busy;

   dsp_mac_tag_pipe #(
      .M_LAT (M_LAT)
   ) u_tag_pipe (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_v        (accept),
      .in_first    (accept & first_pend),
      .in_last     (accept & cnt_last),
      .front_v     (front_v),
      .front_first (front_first),
      .front_busy  (front_busy),
      .back_v      (back_v),
      .back_last   (back_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         first_pend <= 1'b0;
         result     <= '0;
         dsp_rstp   <= 1'b0;
         ce_on      <= 1'b0;
      end else begin
         ce_on    <= 1'b1;
         dsp_rstp <= 1'b0;
         if (flush) begin
            state    <= IDLE;
            dsp_rstp <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     if (len != '0) begin
                        state      <= FEED;
                        count      <= len;
                        first_pend <= 1'b1;
                     end else begin
                        state  <= HOLD;
                        result <= '0;
                     end
                  end
               end
               FEED: begin
                  if (accept) begin
                     count      <= count - LEN_W'(1);
                     first_pend <= 1'b0;
                     if (cnt_last) state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (drain_done) state <= CAPTURE;
               end
               CAPTURE: begin
                  result <= dsp_p;
                  state  <= HOLD;
               end
               HOLD: begin
                  if (result_ready) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef DSP_MAC_OVF_EN
   logic opm_acc_q;
   logic acc_upd_q;
   logic ovf_q;

   // Carry-out is registered in the slice, so it reflects an accumulate one cycle after cep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opm_acc_q <= 1'b0;
         acc_upd_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         opm_acc_q <= (dsp_opmode == OPM_ACC);
         acc_upd_q <= opm_acc_q & dsp_cep;
         if (state == IDLE && start) ovf_q <= 1'b0;
         else if (acc_upd_q && dsp_carryout) ovf_q <= 1'b1;
      end
   end

   assign result_ovf = result_valid & ovf_q;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice; define DSP_MAC_OVF_EN for the overflow build.
module tb_dsp_mac_sequencer;

`ifdef DSP_MAC_OVF_EN
   localparam int LEN_W = 13;
`else
   localparam int LEN_W = 8;
`endif
   localparam int M_LAT   = 2;
   localparam int RES_LAT = M_LAT + 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             abort = 1'b0;
   logic             busy;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [17:0]      s_a = '0;
   logic [17:0]      s_b = '0;
   logic [17:0]      dsp_a, dsp_b;
   logic             dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rstp;
   logic [7:0]       dsp_opmode;
   logic [47:0]      dsp_p;
   logic [47:0]      result;
   logic             result_valid;
   logic             result_ready = 1'b0;
`ifdef DSP_MAC_OVF_EN
   logic             dsp_carryout;
   logic             result_ovf;
   logic             ovf_seen;
`endif

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   dsp_mac_sequencer #(.LEN_W(LEN_W), .M_LAT(M_LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .len          (len),
      .abort        (abort),
      .busy         (busy),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_a          (s_a),
      .s_b          (s_b),
      .dsp_a        (dsp_a),
      .dsp_b        (dsp_b),
      .dsp_cea      (dsp_cea),
      .dsp_ceb      (dsp_ceb),
      .dsp_cem      (dsp_cem),
      .dsp_ceopmode (dsp_ceopmode),
      .dsp_cep      (dsp_cep),
      .dsp_rstp     (dsp_rstp),
      .dsp_opmode   (dsp_opmode),
      .dsp_p        (dsp_p),
`ifdef DSP_MAC_OVF_EN
      .dsp_carryout (dsp_carryout),
      .result_ovf   (result_ovf),
`endif
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   // Slice model: A1/B1 -> M (unsigned 18x18) -> P, OPMODE registered, post-adder only.
   logic [17:0] a1_q, b1_q;
   logic [35:0] m_q;
   logic [7:0]  opm_q;
   logic [47:0] p_q;
   logic [47:0] x_mux, z_mux;
   assign x_mux = (opm_q[1:0] == 2'b01 && opm_q[7:4] == 4'h0) ? 48'(m_q) : 48'd0;
   assign z_mux = (opm_q[3:2] == 2'b10) ? p_q : 48'd0;
`ifdef DSP_MAC_OVF_EN
   logic co_q;
   assign dsp_carryout = co_q;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_q  <= '0;
         b1_q  <= '0;
         m_q   <= '0;
         opm_q <= '0;
         p_q   <= '0;
`ifdef DSP_MAC_OVF_EN
         co_q  <= 1'b0;
`endif
      end else begin
         if (dsp_cea) a1_q <= dsp_a;
         if (dsp_ceb) b1_q <= dsp_b;
         if (dsp_cem) m_q <= 36'(a1_q) * 36'(b1_q);
         if (dsp_ceopmode) opm_q <= dsp_opmode;
`ifdef DSP_MAC_OVF_EN
         if (dsp_rstp) begin
            p_q  <= '0;
            co_q <= 1'b0;
         end else if (dsp_cep) {co_q, p_q} <= 49'(x_mux) + 49'(z_mux);
`else
         if (dsp_rstp) p_q <= '0;
         else if (dsp_cep) p_q <= x_mux + z_mux;
`endif
      end
   end
   assign dsp_p = p_q;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   function automatic logic [47:0] ref_sum(input logic [17:0] aq[$], input logic [17:0] bq[$]);
      logic [47:0] acc;
      acc = '0;
      foreach (aq[i]) acc = acc + 48'(aq[i]) * 48'(bq[i]);
      return acc;
   endfunction

   // One complete job: start, feed, wait for result, optionally stall result_ready while pulsing start.
   task automatic run_job(input logic [17:0] aq[$], input logic [17:0] bq[$], input int gap, input int hold_cyc,
                          output logic [47:0] res, output int lat, output int ceps,
                          output bit sready_low, output bit hold_ok, output bit timed_out);
      int n, i, gcnt, guard;
      logic [47:0] held;
      n = aq.size(); i = 0; gcnt = 0; guard = 0;
      ceps = 0; timed_out = 0; hold_ok = 1;
      start = 1'b1; len = LEN_W'(n);
      tick;
      start = 1'b0;
      while (i < n && guard < 8 * n + 100) begin
         s_valid = (gcnt == 0);
         s_a = aq[i];
         s_b = bq[i];
         ceps += dsp_cep ? 1 : 0;
         if (s_valid && s_ready) begin
            i++;
            gcnt = gap;
         end else if (gcnt > 0) gcnt--;
         tick;
         guard++;
      end
      s_valid = 1'b0;
      if (i < n) timed_out = 1;
      sready_low = !s_ready;
      lat = 1;
      while (!result_valid && lat < 64) begin
         ceps += dsp_cep ? 1 : 0;
         tick;
         lat++;
      end
      if (!result_valid) timed_out = 1;
      res  = result;
      held = result;
`ifdef DSP_MAC_OVF_EN
      ovf_seen = result_ovf;
`endif
      repeat (hold_cyc) begin
         start = 1'b1;
         ceps += dsp_cep ? 1 : 0;
         if (result !== held || !result_valid || !busy) hold_ok = 0;
         tick;
      end
      result_ready = 1'b1;
      ceps += dsp_cep ? 1 : 0;
      tick;
      result_ready = 1'b0;
      start = 1'b0;
      if (busy || s_ready) hold_ok = 0;
   endtask

   task automatic wait_rv(output bit tout);
      int g;
      g = 0;
      while (!result_valid && g < 64) begin
         tick;
         g++;
      end
      tout = !result_valid;
   endtask

   typedef struct {
      int          n;
      logic [17:0] a0;
      logic [17:0] astep;
      logic [17:0] b;
      int          gap;
      int          hold;
      logic [47:0] exp_sum;
      int          exp_lat;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [6];
      logic [17:0] aq[$], bq[$];
      logic [47:0] res;
      int          lat, ceps, cnt, n, gap, hold;
      bit          srl, hok, tout;

      vecs[0] = '{n:4, a0:18'd1, astep:18'd1, b:18'd2, gap:0, hold:0, exp_sum:48'd20, exp_lat:RES_LAT};
      vecs[1] = '{n:3, a0:18'd3, astep:18'd0, b:18'd3, gap:2, hold:0, exp_sum:48'd27, exp_lat:RES_LAT};
      vecs[2] = '{n:0, a0:18'd0, astep:18'd0, b:18'd0, gap:0, hold:0, exp_sum:48'd0, exp_lat:1};
      vecs[3] = '{n:1, a0:18'h3FFFF, astep:18'd0, b:18'h3FFFF, gap:0, hold:0, exp_sum:48'h0000_000F_FFF8_0001, exp_lat:RES_LAT};
      vecs[4] = '{n:5, a0:18'd100, astep:18'd100, b:18'd1000, gap:1, hold:0, exp_sum:48'd1500000, exp_lat:RES_LAT};
      vecs[5] = '{n:2, a0:18'd5, astep:18'd6, b:18'd7, gap:0, hold:10, exp_sum:48'd112, exp_lat:RES_LAT};

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_cep", 64'(dsp_cep), 64'd0);
      check("rst_rstp", 64'(dsp_rstp), 64'd0);
      check("rst_opmode", 64'(dsp_opmode), 64'h00);
      check("rst_result", 64'(result), 64'd0);
      check("rst_result_valid", 64'(result_valid), 64'd0);
      rst_n = 1'b1;
      tick;
      check("cem_after_reset", 64'(dsp_cem), 64'd1);
      check("ceopmode_after_reset", 64'(dsp_ceopmode), 64'd1);

      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("idle_abort_rstp", 64'(dsp_rstp), 64'd0);
      check("idle_abort_busy", 64'(busy), 64'd0);

      for (int k = 0; k < 6; k++) begin
         aq.delete();
         bq.delete();
         for (int j = 0; j < vecs[k].n; j++) begin
            aq.push_back(vecs[k].a0 + 18'(j) * vecs[k].astep);
            bq.push_back(vecs[k].b);
         end
         run_job(aq, bq, vecs[k].gap, vecs[k].hold, res, lat, ceps, srl, hok, tout);
         check($sformatf("vec%0d_done", k), 64'(tout), 64'd0);
         check($sformatf("vec%0d_result", k), 64'(res), 64'(vecs[k].exp_sum));
         check($sformatf("vec%0d_latency", k), 64'(lat), 64'(vecs[k].exp_lat));
         check($sformatf("vec%0d_cep_pulses", k), 64'(ceps), 64'(vecs[k].n));
         check($sformatf("vec%0d_s_ready_low", k), 64'(srl), 64'd1);
         check($sformatf("vec%0d_hold_stable", k), 64'(hok), 64'd1);
      end

      // OPMODE sequence for a two-sample job: FIRST, then ACC, then back to IDLE.
      start = 1'b1; len = LEN_W'(2);
      tick;
      start = 1'b0; s_valid = 1'b1; s_a = 18'd4; s_b = 18'd4;
      tick;
      check("opm_first", 64'(dsp_opmode), 64'h01);
      tick;
      s_valid = 1'b0;
      check("opm_acc", 64'(dsp_opmode), 64'h09);
      check("cep_first_product", 64'(dsp_cep), 64'd1);
      tick;
      check("opm_idle", 64'(dsp_opmode), 64'h00);
      wait_rv(tout);
      check("opm_job_done", 64'(tout), 64'd0);
      check("opm_job_result", 64'(result), 64'd32);
      result_ready = 1'b1;
      tick;
      result_ready = 1'b0;

      // Abort after two of five samples, with a third sample offered in the abort cycle.
      start = 1'b1; len = LEN_W'(5);
      tick;
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         s_valid = 1'b1; s_a = 18'(k + 1); s_b = 18'd1;
         tick;
      end
      s_a = 18'd9; abort = 1'b1;
      tick;
      abort = 1'b0; s_valid = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_rstp", 64'(dsp_rstp), 64'd1);
      tick;
      check("abort_rstp_one_cycle", 64'(dsp_rstp), 64'd0);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         cnt += (dsp_cep || result_valid) ? 1 : 0;
         tick;
      end
      check("abort_no_activity", 64'(cnt), 64'd0);
      aq = '{18'd3};
      bq = '{18'd5};
      run_job(aq, bq, 0, 0, res, lat, ceps, srl, hok, tout);
      check("post_abort_done", 64'(tout), 64'd0);
      check("post_abort_result", 64'(res), 64'd15);
      check("post_abort_latency", 64'(lat), 64'(RES_LAT));

      for (int k = 0; k < 16; k++) begin
         n    = int'($urandom_range(1, 12));
         gap  = int'($urandom_range(0, 2));
         hold = int'($urandom_range(0, 3));
         aq.delete();
         bq.delete();
         for (int j = 0; j < n; j++) begin
            aq.push_back(18'($urandom));
            bq.push_back(18'($urandom));
         end
         run_job(aq, bq, gap, hold, res, lat, ceps, srl, hok, tout);
         check($sformatf("rnd%0d_done", k), 64'(tout), 64'd0);
         check($sformatf("rnd%0d_result", k), 64'(res), 64'(ref_sum(aq, bq)));
         check($sformatf("rnd%0d_latency", k), 64'(lat), 64'(RES_LAT));
         check($sformatf("rnd%0d_cep_pulses", k), 64'(ceps), 64'(n));
         check($sformatf("rnd%0d_hold_stable", k), 64'(hok), 64'd1);
      end

`ifdef DSP_MAC_OVF_EN
      aq.delete();
      bq.delete();
      for (int j = 0; j < 4097; j++) begin
         aq.push_back(18'h3FFFF);
         bq.push_back(18'h3FFFF);
      end
      run_job(aq, bq, 0, 0, res, lat, ceps, srl, hok, tout);
      check("ovf_big_done", 64'(tout), 64'd0);
      check("ovf_big_result", 64'(res), 64'(ref_sum(aq, bq)));
      check("ovf_big_flag", 64'(ovf_seen), 64'd1);
      check("ovf_idle_low", 64'(result_ovf), 64'd0);
      aq = '{18'd1, 18'd2};
      bq = '{18'd3, 18'd3};
      run_job(aq, bq, 0, 0, res, lat, ceps, srl, hok, tout);
      check("ovf_small_result", 64'(res), 64'd9);
      check("ovf_small_flag", 64'(ovf_seen), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
